// File: rtl/bk_adder_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder.
package bk_adder_pkg;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 3;
  localparam int unsigned WIDTH_MIN   = 2;
  localparam int unsigned WIDTH_MAX   = 64;

  // Group generate/propagate pair for one prefix-tree node.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of tree levels needed to cover 'width' positions: ceil(log2(width)).
  function automatic int unsigned bk_levels(input int unsigned width);
    int unsigned lv;
    lv = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(width)) lv = i + 1;
    end
    return lv;
  endfunction

  // Prefix operator: 'hi' covers the more significant span, 'lo' the span below it.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_level.sv
// One combinational level of the Brent-Kung tree, up-sweep or down-sweep.
module bk_prefix_level
  import bk_adder_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned LEVEL = 0,
  parameter bit          UP    = 1'b1
) (
  input  gp_t [N-1:0] gp,
  output gp_t [N-1:0] gp_next_c
);

  localparam int unsigned SPAN   = 32'd1 << LEVEL;
  localparam int unsigned STRIDE = SPAN * 2;

  // Up-sweep merges pairs ending on stride boundaries; down-sweep fills the mid-points.
  for (genvar i = 0; i < N; i++) begin : g_node
    localparam int unsigned POS    = 32'(i) + 32'd1;
    localparam bit          ACTIVE = UP ? ((POS % STRIDE) == 0)
                                        : (((POS % STRIDE) == SPAN) && (POS > STRIDE));
    if (ACTIVE) begin : g_merge
      assign gp_next_c[i] = gp_combine(gp[i], gp[i-SPAN]);
    end else begin : g_pass
      assign gp_next_c[i] = gp[i];
    end
  end

endmodule

// File: rtl/bk_pipe_adder.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready handshake.
// Optional feature: define BK_OVF_EN to add the out_ovf signed-overflow port.
module bk_pipe_adder
  import bk_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
`ifdef BK_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  // Tree positions: 0 holds the carry-in, 1..WIDTH hold operand bits.
  localparam int unsigned M = WIDTH + 1;
  localparam int unsigned L = bk_levels(M);
  localparam int unsigned N = 32'd1 << L;

  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX) ||
      (WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_param
    $error("bk_pipe_adder: WIDTH or LATENCY out of range");
  end

  logic s0_ready, s1_ready, s2_ready;

  // ---------------- P0: bitwise generate/propagate ----------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  gp_t [N-1:0]      p0_gp;

  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;
  assign p0_gp[0] = '{g: cin_eff, p: 1'b0};

  for (genvar j = 0; j < WIDTH; j++) begin : g_p0
    assign p0_gp[j+1] = '{g: in_a[j] & b_eff[j], p: in_a[j] ^ b_eff[j]};
  end
  for (genvar j = WIDTH + 1; j < N; j++) begin : g_pad
    assign p0_gp[j] = '0;
  end

  // ---------------- Stage register after P0 (LATENCY=3 only) ----------------
  logic        a_valid;
  gp_t [N-1:0] a_gp;

  if (LATENCY == 3) begin : g_s0_reg
    logic        v0_q;
    gp_t [N-1:0] gp0_q;

    // Capture P0 results; data only moves on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v0_q  <= 1'b0;
        gp0_q <= '0;
      end else if (s0_ready) begin
        v0_q <= in_valid;
        if (in_valid) gp0_q <= p0_gp;
      end
    end

    assign s0_ready = ~v0_q | s1_ready;
    assign a_valid  = v0_q;
    assign a_gp     = gp0_q;
  end else begin : g_s0_pass
    assign s0_ready = s1_ready;
    assign a_valid  = in_valid;
    assign a_gp     = p0_gp;
  end

  assign in_ready = s0_ready;

  // ---------------- P1: up-sweep ----------------
  gp_t [N-1:0]      up_lvl [L+1];
  logic [WIDTH-1:0] a_p;

  assign up_lvl[0] = a_gp;

  for (genvar l = 0; l < L; l++) begin : g_up
    bk_prefix_level #(.N(N), .LEVEL(l), .UP(1'b1)) u_level (
      .gp        (up_lvl[l]),
      .gp_next_c (up_lvl[l+1])
    );
  end

  // Bitwise propagate is kept separately; the tree overwrites some nodes.
  for (genvar j = 0; j < WIDTH; j++) begin : g_ap
    assign a_p[j] = a_gp[j+1].p;
  end

  // ---------------- Stage register after P1 (LATENCY>=2) ----------------
  logic             b_valid;
  gp_t [N-1:0]      b_up;
  logic [WIDTH-1:0] b_p;

  if (LATENCY >= 2) begin : g_s1_reg
    logic             v1_q;
    gp_t [N-1:0]      up1_q;
    logic [WIDTH-1:0] p1_q;

    // Capture up-sweep tree and bitwise propagate.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q  <= 1'b0;
        up1_q <= '0;
        p1_q  <= '0;
      end else if (s1_ready) begin
        v1_q <= a_valid;
        if (a_valid) begin
          up1_q <= up_lvl[L];
          p1_q  <= a_p;
        end
      end
    end

    assign s1_ready = ~v1_q | s2_ready;
    assign b_valid  = v1_q;
    assign b_up     = up1_q;
    assign b_p      = p1_q;
  end else begin : g_s1_pass
    assign s1_ready = s2_ready;
    assign b_valid  = a_valid;
    assign b_up     = up_lvl[L];
    assign b_p      = a_p;
  end

  // ---------------- P2: down-sweep, carries, sum ----------------
  gp_t [N-1:0]    dn_lvl [L];
  gp_t [N-1:0]    prefix;
  logic [WIDTH:0] sum;
  logic           unused_prefix;

  assign dn_lvl[0] = b_up;

  for (genvar k = 0; k < L - 1; k++) begin : g_dn
    bk_prefix_level #(.N(N), .LEVEL(L - 2 - k), .UP(1'b0)) u_level (
      .gp        (dn_lvl[k]),
      .gp_next_c (dn_lvl[k+1])
    );
  end

  assign prefix = dn_lvl[L-1];

  // prefix[j].g is the carry into operand bit j; prefix[WIDTH].g is carry-out.
  for (genvar j = 0; j < WIDTH; j++) begin : g_sum
    assign sum[j] = b_p[j] ^ prefix[j].g;
  end
  assign sum[WIDTH]    = prefix[WIDTH].g;
  assign unused_prefix = ^prefix;

`ifdef BK_OVF_EN
  logic ovf;
  assign ovf = prefix[WIDTH-1].g ^ prefix[WIDTH].g;
`endif

  // ---------------- Output register ----------------
  assign s2_ready = ~out_valid | out_ready;

  // Result register; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef BK_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else if (s2_ready) begin
      out_valid <= b_valid;
      if (b_valid) begin
        out_sum <= sum;
`ifdef BK_OVF_EN
        out_ovf <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Self-checking bench: directed cases on a 12-bit/3-stage instance, then
// randomized streams on four width/latency configurations against an arithmetic model.
module tb_bk_pipe_adder;

  localparam int          NDUT  = 4;
  localparam int unsigned W0    = 12;
  localparam int unsigned W1    = 7;
  localparam int unsigned W2    = 32;
  localparam int unsigned W3    = 64;
  localparam int          N_RAND = 2600;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv   [NDUT];
  logic        icin [NDUT];
  logic        isub [NDUT];
  logic        ordy [NDUT];
  logic [63:0] ia   [NDUT];
  logic [63:0] ib   [NDUT];
  logic        ir   [NDUT];
  logic        ov   [NDUT];
  logic        oovf [NDUT];
  logic [64:0] osum [NDUT];

  logic ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
  logic [W0:0] s0;
  logic [W1:0] s1;
  logic [W2:0] s2;
  logic [W3:0] s3;
`ifdef BK_OVF_EN
  logic f0, f1, f2, f3;
`endif

  int checks = 0;
  int errors = 0;

  logic [65:0] q0 [$];
  logic [65:0] q1 [$];
  logic [65:0] q2 [$];
  logic [65:0] q3 [$];

  always #5 clk = ~clk;

  bk_pipe_adder #(.WIDTH(W0), .LATENCY(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
    .in_a(ia[0][W0-1:0]), .in_b(ib[0][W0-1:0]), .in_cin(icin[0]), .in_sub(isub[0]),
    .out_valid(ov0), .out_ready(ordy[0]), .out_sum(s0)
`ifdef BK_OVF_EN
    , .out_ovf(f0)
`endif
  );

  bk_pipe_adder #(.WIDTH(W1), .LATENCY(1)) u_dut_w7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
    .in_a(ia[1][W1-1:0]), .in_b(ib[1][W1-1:0]), .in_cin(icin[1]), .in_sub(isub[1]),
    .out_valid(ov1), .out_ready(ordy[1]), .out_sum(s1)
`ifdef BK_OVF_EN
    , .out_ovf(f1)
`endif
  );

  bk_pipe_adder #(.WIDTH(W2), .LATENCY(2)) u_dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
    .in_a(ia[2][W2-1:0]), .in_b(ib[2][W2-1:0]), .in_cin(icin[2]), .in_sub(isub[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .out_sum(s2)
`ifdef BK_OVF_EN
    , .out_ovf(f2)
`endif
  );

  bk_pipe_adder #(.WIDTH(W3), .LATENCY(3)) u_dut_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir3),
    .in_a(ia[3][W3-1:0]), .in_b(ib[3][W3-1:0]), .in_cin(icin[3]), .in_sub(isub[3]),
    .out_valid(ov3), .out_ready(ordy[3]), .out_sum(s3)
`ifdef BK_OVF_EN
    , .out_ovf(f3)
`endif
  );

  // Gather per-instance outputs into uniform 65-bit views.
  always_comb begin
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2; ir[3] = ir3;
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2; ov[3] = ov3;
    osum[0] = 65'(s0); osum[1] = 65'(s1); osum[2] = 65'(s2); osum[3] = 65'(s3);
`ifdef BK_OVF_EN
    oovf[0] = f0; oovf[1] = f1; oovf[2] = f2; oovf[3] = f3;
`else
    oovf[0] = 1'b0; oovf[1] = 1'b0; oovf[2] = 1'b0; oovf[3] = 1'b0;
`endif
  end

  function automatic int unsigned wid(input int d);
    case (d)
      0:       return W0;
      1:       return W1;
      2:       return W2;
      default: return W3;
    endcase
  endfunction

  // Reference: {signed overflow, (A + B' + cin') mod 2^(w+1)} by plain arithmetic.
  function automatic logic [65:0] ref_res(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin,
                                          input logic sub);
    logic [64:0] m, aa, bb, s;
    logic        c, ovf;
    m   = (65'd1 << w) - 65'd1;
    aa  = {1'b0, a} & m;
    bb  = sub ? (~{1'b0, b}) & m : {1'b0, b} & m;
    c   = sub ? 1'b1 : cin;
    s   = aa + bb + 65'(c);
    ovf = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ovf, s};
  endfunction

  function automatic logic [63:0] rnd_op(input int unsigned w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0:       return m;
      1:       return 64'd0;
      2:       return 64'd1 << (w - 1);
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int d, input logic [65:0] v);
    case (d)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      2:       q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int d, output logic [65:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (d)
      0:       if (q0.size() != 0) begin v = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() != 0) begin v = q1.pop_front(); ok = 1'b1; end
      2:       if (q2.size() != 0) begin v = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() != 0) begin v = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Single beat on the 12-bit instance: checks latency, sum and (if built) overflow.
  task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic [12:0] exp_sum,
                        input logic exp_ovf);
    int lat;
    int guard;
    @(negedge clk);
    ia[0] = a; ib[0] = b; icin[0] = cin; isub[0] = sub; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    guard = 0;
    while (!ir[0] && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 66'(lat), 66'(3));
    check({tag, "_sum"}, 66'(osum[0]), 66'(exp_sum));
`ifdef BK_OVF_EN
    check({tag, "_ovf"}, 66'(oovf[0]), 66'(exp_ovf));
`else
    if (exp_ovf === 1'bx) check({tag, "_ovf"}, 66'(oovf[0]), 66'(0));
`endif
  endtask

  logic [63:0] bp_a [6];
  logic [63:0] bp_b [6];
  logic [65:0] bp_exp [6];
  int          k, r, guard, cyc;
  bit          acc, acc_i, acc_o, seen, ok, all_done;
  logic [64:0] obs;
  logic [65:0] ev;
  int          sent [NDUT];
  int          done [NDUT];
  bit          acc_in [NDUT];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      iv[d] = 1'b0; icin[d] = 1'b0; isub[d] = 1'b0; ordy[d] = 1'b1;
      ia[d] = '0; ib[d] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_valid_d%0d", d), 66'(ov[d]), 66'(0));
      check($sformatf("rst_sum_d%0d", d), 66'(osum[d]), 66'(0));
      check($sformatf("rst_ovf_d%0d", d), 66'(oovf[d]), 66'(0));
      check($sformatf("rst_in_ready_d%0d", d), 66'(ir[d]), 66'(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 66'(ir[0]), 66'(1));

    // Directed arithmetic cases
    single("add_carry",     64'hFFF, 64'h001, 1'b0, 1'b0, 13'h1000, 1'b0);
    single("sub_borrow",    64'h005, 64'h007, 1'b0, 1'b1, 13'h0FFE, 1'b0);
    single("sub_noborrow",  64'h007, 64'h005, 1'b0, 1'b1, 13'h1002, 1'b0);
    single("sub_cin_ign",   64'h007, 64'h005, 1'b1, 1'b1, 13'h1002, 1'b0);
    single("add_cin",       64'h123, 64'h456, 1'b1, 1'b0, 13'h057A, 1'b0);
    single("ovf_pos",       64'h7FF, 64'h001, 1'b0, 1'b0, 13'h0800, 1'b1);
    single("ovf_neg",       64'h800, 64'hFFF, 1'b0, 1'b0, 13'h17FF, 1'b1);
    single("no_ovf",        64'h001, 64'h001, 1'b0, 1'b0, 13'h0002, 1'b0);

    // Backpressure: six back-to-back beats into a stalled consumer
    for (int i = 0; i < 6; i++) begin
      bp_a[i]   = 64'($urandom_range(0, 4095));
      bp_b[i]   = 64'($urandom_range(0, 4095));
      bp_exp[i] = ref_res(W0, bp_a[i], bp_b[i], 1'b0, (i % 2) == 1);
    end
    @(negedge clk);
    ordy[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      iv[0] = (k < 6);
      if (k < 6) begin
        ia[0] = bp_a[k]; ib[0] = bp_b[k]; icin[0] = 1'b0; isub[0] = (k % 2) == 1;
      end
      #1;
      acc = iv[0] && ir[0];
      if (c == 4) check("bp_hold_sum_early", 66'(osum[0]), 66'(bp_exp[0][64:0]));
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    #1;
    check("bp_accepted", 66'(k), 66'(3));
    check("bp_in_ready_low", 66'(ir[0]), 66'(0));
    check("bp_out_valid", 66'(ov[0]), 66'(1));
    check("bp_hold_sum", 66'(osum[0]), 66'(bp_exp[0][64:0]));
    ordy[0] = 1'b1;
    #1;
    check("bp_ready_same_cycle", 66'(ir[0]), 66'(1));
    r = 0;
    guard = 0;
    while (r < 6 && guard < 40) begin
      guard++;
      acc_i = iv[0] && ir[0];
      acc_o = ov[0] && ordy[0];
      obs   = osum[0];
      if (acc_o) begin
        check($sformatf("bp_order_%0d", r), 66'(obs), 66'(bp_exp[r][64:0]));
        r++;
      end
      @(posedge clk); #1;
      if (acc_i) k++;
      iv[0] = (k < 6);
      if (k < 6) begin
        ia[0] = bp_a[k]; ib[0] = bp_b[k]; isub[0] = (k % 2) == 1;
      end
      @(negedge clk); #1;
    end
    iv[0] = 1'b0;
    check("bp_all_out", 66'(r), 66'(6));

    // Reset with three beats in flight
    @(negedge clk);
    ordy[0] = 1'b1;
    isub[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1;
      ia[0] = 64'($urandom_range(0, 4095));
      ib[0] = 64'($urandom_range(0, 4095));
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    check("rst_mid_pre_valid", 66'(ov[0]), 66'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 66'(ov[0]), 66'(0));
    check("rst_mid_sum", 66'(osum[0]), 66'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ov[0];
    end
    check("rst_no_stale", 66'(seen), 66'(0));

    // Randomized streams on all four configurations
    for (int d = 0; d < NDUT; d++) begin
      sent[d] = 0; done[d] = 0; iv[d] = 1'b0;
    end
    cyc = 0;
    all_done = 1'b0;
    @(negedge clk);
    while (!all_done && cyc < 40000) begin
      for (int d = 0; d < NDUT; d++) begin
        ordy[d] = ($urandom_range(0, 3) != 0);
        if (!iv[d] && sent[d] < N_RAND && $urandom_range(0, 4) != 0) begin
          iv[d]   = 1'b1;
          ia[d]   = rnd_op(wid(d));
          ib[d]   = rnd_op(wid(d));
          icin[d] = 1'($urandom_range(0, 1));
          isub[d] = 1'($urandom_range(0, 1));
        end
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
        acc_in[d] = iv[d] && ir[d];
        if (ov[d] && ordy[d]) begin
          pop_exp(d, ev, ok);
          if (!ok) begin
            check($sformatf("rnd_spurious_d%0d", d), 66'(ov[d]), 66'(0));
          end else begin
`ifdef BK_OVF_EN
            check($sformatf("rnd_d%0d_n%0d", d, done[d]), {oovf[d], osum[d]}, ev);
`else
            check($sformatf("rnd_d%0d_n%0d", d, done[d]), 66'(osum[d]), 66'(ev[64:0]));
`endif
          end
          done[d]++;
        end
        if (acc_in[d]) begin
          push_exp(d, ref_res(wid(d), ia[d], ib[d], icin[d], isub[d]));
          sent[d]++;
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
        if (acc_in[d]) iv[d] = 1'b0;
      end
      @(negedge clk);
      cyc++;
      all_done = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        if (done[d] < N_RAND) all_done = 1'b0;
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rnd_count_d%0d", d), 66'(done[d]), 66'(N_RAND));
      check($sformatf("rnd_leftover_d%0d", d), 66'(qsize(d)), 66'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
